// File: rtl/ma_block.sv
// Memory-access stage: load/store over req/ack, MEM/WB result register.
// Optional WAIT-abort timeout when MA_TIMEOUT_EN is defined.
module ma_block #(
  parameter int WIDTH   = 64,
  parameter int ADDR    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             p_Clk,
  input  logic             p_Reset,
  input  logic             p_MA_Valid,
  input  logic [WIDTH-1:0] p_MA_ALUResult,
  input  logic [WIDTH-1:0] p_MA_WriteData,
  input  logic [ADDR-1:0]  p_MA_WriteAddress,
  input  logic [5:0]       p_MA_Ctrl_Bus,
  output logic             p_MA_Stall,
  output logic             p_Mem_Req,
  output logic             p_Mem_We,
  output logic [WIDTH-1:0] p_Mem_Addr,
  output logic [WIDTH-1:0] p_Mem_WData,
  output logic [7:0]       p_Mem_ByteEn,
  input  logic             p_Mem_Ack,
  input  logic [WIDTH-1:0] p_Mem_RData,
  output logic             p_WB_Valid,
  output logic             p_WB_RegWrite,
  output logic [WIDTH-1:0] p_WB_Data,
  output logic [ADDR-1:0]  p_WB_Address,
  output logic             p_MA_AlignErr,
  output logic             p_MA_BusErr
);

  typedef enum logic [0:0] {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0] lat_data;
  logic [5:0]       lat_ctrl;
  logic [ADDR-1:0]  lat_dest;

  logic             is_mem;
  logic             mis;
  logic             accept;
  logic             in_wait;
  logic             done;
  logic             abort;
  logic [2:0]       la;
  logic [7:0]       be_c;
  logic [WIDTH-1:0] wdata_c;
  logic [WIDTH-1:0] load_ext;
  logic [7:0]       ld_b;
  logic [15:0]      ld_h;
  logic [31:0]      ld_w;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("TIMEOUT must fit the 8-bit counter");
  end

  assign is_mem = p_MA_Ctrl_Bus[0] | p_MA_Ctrl_Bus[1];

  always_comb begin
    mis = 1'b0;
    unique case (p_MA_Ctrl_Bus[3:2])
      2'b00: mis = 1'b0;
      2'b01: mis = p_MA_ALUResult[0];
      2'b10: mis = |p_MA_ALUResult[1:0];
      2'b11: mis = |p_MA_ALUResult[2:0];
    endcase
  end

  assign in_wait = (state == S_WAIT);
  assign accept  = (state == S_IDLE) & p_MA_Valid & is_mem & ~mis;
  assign done    = in_wait & p_Mem_Ack;

`ifdef MA_TIMEOUT_EN
  localparam logic [7:0] TmoLim = 8'(TIMEOUT - 1);

  logic [7:0] tmo_cnt;
  logic       bus_err_q;

  assign abort = in_wait & ~p_Mem_Ack & (tmo_cnt == TmoLim);

  always_ff @(posedge p_Clk) begin
    if (p_Reset) begin
      tmo_cnt   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= abort;
      if (accept)
        tmo_cnt <= '0;
      else if (in_wait && !p_Mem_Ack)
        tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign p_MA_BusErr = bus_err_q;
`else
  assign abort       = 1'b0;
  assign p_MA_BusErr = 1'b0;
`endif

  always_comb begin
    state_next = state;
    p_MA_Stall = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_WAIT;
          p_MA_Stall = 1'b1;
        end
      end
      S_WAIT: begin
        p_MA_Stall = ~p_Mem_Ack & ~abort;
        if (done || abort)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge p_Clk) begin
    if (p_Reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  assign la = lat_addr[2:0];

  always_comb begin
    be_c    = 8'h00;
    wdata_c = '0;
    unique case (lat_ctrl[3:2])
      2'b00: begin
        be_c    = 8'(8'h01 << la);
        wdata_c = {(WIDTH/8){lat_data[7:0]}};
      end
      2'b01: begin
        be_c    = 8'(8'h03 << la);
        wdata_c = {(WIDTH/16){lat_data[15:0]}};
      end
      2'b10: begin
        be_c    = 8'(8'h0F << la);
        wdata_c = {(WIDTH/32){lat_data[31:0]}};
      end
      2'b11: begin
        be_c    = 8'hFF;
        wdata_c = lat_data;
      end
    endcase
  end

  assign p_Mem_Req    = in_wait;
  assign p_Mem_We     = in_wait & lat_ctrl[1];
  assign p_Mem_Addr   = in_wait ? {lat_addr[WIDTH-1:3], 3'b000} : '0;
  assign p_Mem_WData  = in_wait ? wdata_c : '0;
  assign p_Mem_ByteEn = in_wait ? be_c : 8'h00;

  // Little-endian lane pick, then sign/zero extension
  assign ld_b = p_Mem_RData[{la, 3'b000} +: 8];
  assign ld_h = p_Mem_RData[{la[2:1], 4'b0000} +: 16];
  assign ld_w = p_Mem_RData[{la[2], 5'b00000} +: 32];

  always_comb begin
    load_ext = '0;
    unique case (lat_ctrl[3:2])
      2'b00: load_ext = lat_ctrl[4] ?
        {{(WIDTH-8){1'b0}}, ld_b} :
        {{(WIDTH-8){ld_b[7]}}, ld_b};
      2'b01: load_ext = lat_ctrl[4] ?
        {{(WIDTH-16){1'b0}}, ld_h} :
        {{(WIDTH-16){ld_h[15]}}, ld_h};
      2'b10: load_ext = lat_ctrl[4] ?
        {{(WIDTH-32){1'b0}}, ld_w} :
        {{(WIDTH-32){ld_w[31]}}, ld_w};
      2'b11: load_ext = p_Mem_RData;
    endcase
  end

  always_ff @(posedge p_Clk) begin
    if (p_Reset) begin
      lat_addr      <= '0;
      lat_data      <= '0;
      lat_ctrl      <= '0;
      lat_dest      <= '0;
      p_WB_Valid    <= 1'b0;
      p_WB_RegWrite <= 1'b0;
      p_WB_Data     <= '0;
      p_WB_Address  <= '0;
      p_MA_AlignErr <= 1'b0;
    end else begin
      p_WB_Valid    <= 1'b0;
      p_MA_AlignErr <= 1'b0;
      if (state == S_IDLE) begin
        if (p_MA_Valid && !is_mem) begin
          p_WB_Valid    <= 1'b1;
          p_WB_RegWrite <= p_MA_Ctrl_Bus[5];
          p_WB_Data     <= p_MA_ALUResult;
          p_WB_Address  <= p_MA_WriteAddress;
        end else if (p_MA_Valid && mis) begin
          p_MA_AlignErr <= 1'b1;
          p_WB_RegWrite <= 1'b0;
        end else if (accept) begin
          lat_addr <= p_MA_ALUResult;
          lat_data <= p_MA_WriteData;
          lat_ctrl <= p_MA_Ctrl_Bus;
          lat_dest <= p_MA_WriteAddress;
        end
      end else if (done) begin
        p_WB_Valid   <= 1'b1;
        p_WB_Address <= lat_dest;
        if (lat_ctrl[1]) begin
          p_WB_RegWrite <= 1'b0;
        end else if (lat_ctrl[0]) begin
          p_WB_RegWrite <= lat_ctrl[5];
          p_WB_Data     <= load_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_ma_block.sv
// Directed bench for ma_block: pass-through, loads, store,
// misalignment, reset abort and (optionally) timeout.
module tb_ma_block;

  localparam int WIDTH = 64;
  localparam int ADDR  = 5;
`ifdef MA_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic             clk;
  logic             rst;
  logic             valid;
  logic [WIDTH-1:0] alu;
  logic [WIDTH-1:0] wdata;
  logic [ADDR-1:0]  dest;
  logic [5:0]       ctrl;
  logic             stall;
  logic             req;
  logic             we;
  logic [WIDTH-1:0] maddr;
  logic [WIDTH-1:0] mwdata;
  logic [7:0]       byte_en;
  logic             ack;
  logic [WIDTH-1:0] rdata;
  logic             wb_valid;
  logic             wb_rw;
  logic [WIDTH-1:0] wb_data;
  logic [ADDR-1:0]  wb_addr;
  logic             align_err;
  logic             bus_err;

  int checks;
  int failures;
  int stalls;

  ma_block #(
    .WIDTH(WIDTH),
    .ADDR(ADDR),
    .TIMEOUT(TMO)
  ) dut (
    .p_Clk(clk),
    .p_Reset(rst),
    .p_MA_Valid(valid),
    .p_MA_ALUResult(alu),
    .p_MA_WriteData(wdata),
    .p_MA_WriteAddress(dest),
    .p_MA_Ctrl_Bus(ctrl),
    .p_MA_Stall(stall),
    .p_Mem_Req(req),
    .p_Mem_We(we),
    .p_Mem_Addr(maddr),
    .p_Mem_WData(mwdata),
    .p_Mem_ByteEn(byte_en),
    .p_Mem_Ack(ack),
    .p_Mem_RData(rdata),
    .p_WB_Valid(wb_valid),
    .p_WB_RegWrite(wb_rw),
    .p_WB_Data(wb_data),
    .p_WB_Address(wb_addr),
    .p_MA_AlignErr(align_err),
    .p_MA_BusErr(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    valid = 1'b0;
    alu   = '0;
    wdata = '0;
    dest  = '0;
    ctrl  = '0;
    ack   = 1'b0;
    rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_req", req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_align", align_err, 0);
    chk("rst_bus", bus_err, 0);

    // ALU pass-through
    valid = 1'b1;
    ctrl  = 6'b100000;
    alu   = 64'h1234;
    dest  = 5'd7;
    #1;
    chk("alu_stall", stall, 0);
    tick();
    valid = 1'b0;
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_rw", wb_rw, 1);
    chk("alu_wb_data", wb_data, 64'h1234);
    chk("alu_wb_addr", wb_addr, 7);
    chk("alu_stall2", stall, 0);
    tick();
    chk("idle_wb_valid", wb_valid, 0);
    chk("idle_wb_hold", wb_data, 64'h1234);

    // Signed byte load, ack after 3 wait cycles
    valid  = 1'b1;
    ctrl   = 6'b100001;
    alu    = 64'h1005;
    dest   = 5'd3;
    stalls = 0;
    #1;
    if (stall) stalls++;
    chk("lb_req_accept", req, 0);
    tick();
    valid = 1'b0;
    chk("lb_req", req, 1);
    chk("lb_be", byte_en, 8'h20);
    chk("lb_addr", maddr, 64'h1000);
    chk("lb_we", we, 0);
    chk("lb_wbv_accept", wb_valid, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall) stalls++;
      tick();
    end
    chk("lb_be_held", byte_en, 8'h20);
    ack   = 1'b1;
    rdata = 64'h0000_8000_0000_0000;
    #1;
    chk("lb_stall_ack", stall, 0);
    chk("lb_stall_cnt", 64'(stalls), 4);
    tick();
    ack = 1'b0;
    chk("lb_wb_valid", wb_valid, 1);
    chk("lb_wb_rw", wb_rw, 1);
    chk("lb_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_wb_addr", wb_addr, 3);
    chk("lb_req_done", req, 0);

    // Unsigned half load, immediate ack
    valid = 1'b1;
    ctrl  = 6'b110101;
    alu   = 64'h1006;
    dest  = 5'd9;
    tick();
    valid = 1'b0;
    chk("lhu_be", byte_en, 8'hC0);
    ack   = 1'b1;
    rdata = 64'hFF80_0000_0000_0000;
    tick();
    ack = 1'b0;
    chk("lhu_wb_valid", wb_valid, 1);
    chk("lhu_wb_data", wb_data, 64'h0000_0000_0000_FF80);
    chk("lhu_wb_addr", wb_addr, 9);

    // Word store, MemRead also set, immediate ack
    valid = 1'b1;
    ctrl  = 6'b101011;
    alu   = 64'h2004;
    wdata = 64'h1111_2222_DEAD_BEEF;
    dest  = 5'd4;
    #1;
    chk("sw_stall_accept", stall, 1);
    tick();
    valid = 1'b0;
    chk("sw_we", we, 1);
    chk("sw_be", byte_en, 8'hF0);
    chk("sw_wdata", mwdata, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("sw_addr", maddr, 64'h2000);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("sw_wb_valid", wb_valid, 1);
    chk("sw_wb_rw", wb_rw, 0);
    chk("sw_req_done", req, 0);

    // Misaligned doubleword load
    valid = 1'b1;
    ctrl  = 6'b101101;
    alu   = 64'h3004;
    #1;
    chk("mis_stall", stall, 0);
    chk("mis_req", req, 0);
    tick();
    valid = 1'b0;
    chk("mis_align", align_err, 1);
    chk("mis_wb_valid", wb_valid, 0);
    chk("mis_wb_rw", wb_rw, 0);
    chk("mis_req2", req, 0);
    tick();
    chk("mis_align_pulse", align_err, 0);

    // Reset during WAIT
    valid = 1'b1;
    ctrl  = 6'b100001;
    alu   = 64'h4000;
    dest  = 5'd2;
    tick();
    valid = 1'b0;
    chk("rw_req", req, 1);
    rst = 1'b1;
    tick();
    chk("rw_req_low", req, 0);
    chk("rw_stall", stall, 0);
    chk("rw_be", byte_en, 0);
    chk("rw_wb_valid", wb_valid, 0);
    chk("rw_wb_data", wb_data, 0);
    chk("rw_wb_addr", wb_addr, 0);
    rst = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("rw_no_wb", wb_valid, 0);

`ifdef MA_TIMEOUT_EN
    valid = 1'b1;
    ctrl  = 6'b100001;
    alu   = 64'h5000;
    tick();
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req", req, 1);
      chk("to_stall", stall, (i == 3) ? 1'b0 : 1'b1);
      chk("to_bus_early", bus_err, 0);
      tick();
    end
    chk("to_bus_err", bus_err, 1);
    chk("to_req_low", req, 0);
    chk("to_wb_valid", wb_valid, 0);
    tick();
    chk("to_bus_pulse", bus_err, 0);
`endif

    // ALU op after abort completes normally
    valid = 1'b1;
    ctrl  = 6'b100000;
    alu   = 64'hABCD;
    dest  = 5'd11;
    tick();
    valid = 1'b0;
    chk("post_wb_valid", wb_valid, 1);
    chk("post_wb_data", wb_data, 64'hABCD);
    chk("post_wb_addr", wb_addr, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
